// File: rtl/rgb_pwm_driver_if.sv
// rgb_pwm_driver_if: valid/ready handshake carrying one R/G/B duty triple.
//   in_valid  producer -> driver  in_r/in_g/in_b hold a valid triple
//   in_ready  driver -> producer  driver accepts a triple this cycle
//   in_r/g/b  producer -> driver  per-channel duty words (DUTY_W bits)
interface rgb_pwm_driver_if #(
    parameter int unsigned DUTY_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DUTY_W-1:0] in_r;
    logic [DUTY_W-1:0] in_g;
    logic [DUTY_W-1:0] in_b;

    modport master (
        output in_valid,
        output in_r,
        output in_g,
        output in_b,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_r,
        input  in_g,
        input  in_b,
        output in_ready
    );
endinterface

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: turns per-channel duty words into phase-aligned PWM on
// active-low RGB LED pins. A one-entry pending buffer takes triples over a
// valid/ready handshake; new duties are applied only at PWM period boundaries.
//   clk           system clock
//   rst           synchronous, active-high reset
//   bus           slave side of rgb_pwm_driver_if (in_valid/in_ready/in_r/g/b)
//   RGB_R/G/B     LED pins, active low, registered
//   period_start  one-clk pulse in the first clk of each period (pwm_cnt==0)
module rgb_pwm_driver #(
    parameter int unsigned PRESCALE = 47,
    parameter int unsigned DUTY_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    rgb_pwm_driver_if.slave  bus,
    output logic             RGB_R,
    output logic             RGB_G,
    output logic             RGB_B,
    output logic             period_start
);
    localparam int unsigned       PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] CNT_MAX = {DUTY_W{1'b1}};

    logic [PS_W-1:0]   prescaler;
    logic [DUTY_W-1:0] pwm_cnt;
    logic [DUTY_W-1:0] act_r, act_g, act_b;
    logic [DUTY_W-1:0] pend_r, pend_g, pend_b;
    logic              pending_full;

    logic tick;
    logic boundary;
    logic accept;
    logic on_r, on_g, on_b;

    // Handshake: ready whenever the single pending slot is free.
    assign bus.in_ready = !rst && !pending_full;
    assign accept       = bus.in_valid && bus.in_ready;

    // Timebase decode.
    assign tick     = (prescaler == PS_LAST);
    assign boundary = tick && (pwm_cnt == CNT_MAX);

    // Max duty forces the channel fully on; otherwise compare against the count.
    assign on_r = (pwm_cnt < act_r) || (act_r == CNT_MAX);
    assign on_g = (pwm_cnt < act_g) || (act_g == CNT_MAX);
    assign on_b = (pwm_cnt < act_b) || (act_b == CNT_MAX);

    // Timebase, duty buffers and registered pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler    <= '0;
            pwm_cnt      <= '0;
            act_r        <= '0;
            act_g        <= '0;
            act_b        <= '0;
            pend_r       <= '0;
            pend_g       <= '0;
            pend_b       <= '0;
            pending_full <= 1'b0;
            period_start <= 1'b0;
            RGB_R        <= 1'b1;
            RGB_G        <= 1'b1;
            RGB_B        <= 1'b1;
        end else begin
            prescaler <= tick ? '0 : prescaler + PS_W'(1);
            if (tick) begin
                pwm_cnt <= pwm_cnt + DUTY_W'(1);
            end

            // A full buffer blocks accept, so these two branches never both fire.
            if (boundary && pending_full) begin
                act_r        <= pend_r;
                act_g        <= pend_g;
                act_b        <= pend_b;
                pending_full <= 1'b0;
            end
            if (accept) begin
                pend_r       <= bus.in_r;
                pend_g       <= bus.in_g;
                pend_b       <= bus.in_b;
                pending_full <= 1'b1;
            end

            period_start <= boundary;
            RGB_R        <= ~on_r;
            RGB_G        <= ~on_g;
            RGB_B        <= ~on_b;
        end
    end
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: directed bench for rgb_pwm_driver with a per-period
// scoreboard of expected duty triples (PRESCALE=2, DUTY_W=4, 32-clk period).
module tb_rgb_pwm_driver;
    localparam int unsigned PRESCALE = 2;
    localparam int unsigned DUTY_W   = 4;
    localparam int unsigned PERIOD   = PRESCALE * (1 << DUTY_W);
    localparam logic [DUTY_W-1:0] DMAX = {DUTY_W{1'b1}};

    typedef struct packed {
        logic [DUTY_W-1:0] r;
        logic [DUTY_W-1:0] g;
        logic [DUTY_W-1:0] b;
    } triple_t;

    logic clk;
    logic rst;
    logic RGB_R, RGB_G, RGB_B;
    logic period_start;

    rgb_pwm_driver_if #(.DUTY_W(DUTY_W)) bus ();

    rgb_pwm_driver #(
        .PRESCALE (PRESCALE),
        .DUTY_W   (DUTY_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .RGB_R        (RGB_R),
        .RGB_G        (RGB_G),
        .RGB_B        (RGB_B),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    triple_t exp_q[$];
    int      vectors     = 0;
    int      miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic triple_t mk(input int r, input int g, input int b);
        triple_t t;
        t.r = DUTY_W'(r);
        t.g = DUTY_W'(g);
        t.b = DUTY_W'(b);
        return t;
    endfunction

    // Expected pin trace for one period: bit i is the pin i+1 clks after period_start.
    function automatic logic [31:0] pat(input logic [DUTY_W-1:0] d);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < int'(PERIOD); i++) begin
            v[i] = !(((i / int'(PRESCALE)) < int'(d)) || (d == DMAX));
        end
        return v;
    endfunction

    task automatic wait_ps();
        int n = 0;
        while (period_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("period_start_seen", 32'(period_start), 32'd1);
    endtask

    // Record one full period of pins; in_valid is released on the first sample.
    task automatic capture(output logic [31:0] r, output logic [31:0] g,
                           output logic [31:0] b, output logic [31:0] ps);
        r = '0; g = '0; b = '0; ps = '0;
        for (int i = 0; i < int'(PERIOD); i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            r[i]  = RGB_R;
            g[i]  = RGB_G;
            b[i]  = RGB_B;
            ps[i] = period_start;
        end
    endtask

    task automatic check_period(input string tag, output logic [31:0] g_out);
        triple_t     e;
        logic [31:0] r, g, b, ps;
        wait_ps();
        capture(r, g, b, ps);
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : mk(0, 0, 0);
        chk({tag, "_r"}, r, pat(e.r));
        chk({tag, "_g"}, g, pat(e.g));
        chk({tag, "_b"}, b, pat(e.b));
        chk({tag, "_spacing"}, ps, 32'd1 << (PERIOD - 1));
        g_out = g;
    endtask

    task automatic send(input triple_t t, input bit expect_it);
        int n = 0;
        bus.in_r     = t.r;
        bus.in_g     = t.g;
        bus.in_b     = t.b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (expect_it) exp_q.push_back(t);
    endtask

    initial begin
        logic [31:0] g;
        int          n;
        triple_t     t1, t2, t4;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_r = '0;
        bus.in_g = '0;
        bus.in_b = '0;

        // 1: reset state, then three dark periods
        repeat (5) @(negedge clk);
        chk("rst_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'b111);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_ps", 32'(period_start), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);
        repeat (3) begin
            exp_q.push_back(mk(0, 0, 0));
            check_period("dark", g);
        end

        // 2: R half, G off, B full
        send(mk(8, 0, 15), 1'b1);
        check_period("mix", g);
        exp_q.push_back(mk(8, 0, 15));
        check_period("mix_hold", g);

        // 3: back-to-back triples, second held until the buffer frees
        t1 = mk(4, 4, 4);
        t2 = mk(12, 0, 0);
        send(t1, 1'b1);
        bus.in_r = t2.r;
        bus.in_g = t2.g;
        bus.in_b = t2.b;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t2_blocked_clks", 32'(n), 32'(PERIOD - 1));
        chk("t2_ready_at_ps", 32'(period_start), 32'd1);
        exp_q.push_back(t2);
        check_period("t1", g);
        check_period("t2", g);

        // 4: accept in the exact boundary cycle lands one period later
        repeat (PERIOD - 1) @(negedge clk);
        chk("bnd_ready", 32'(bus.in_ready), 32'd1);
        chk("bnd_not_yet_ps", 32'(period_start), 32'd0);
        t4 = mk(2, 9, 6);
        bus.in_r = t4.r;
        bus.in_g = t4.g;
        bus.in_b = t4.b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bnd_ps", 32'(period_start), 32'd1);
        exp_q.push_back(t2);
        exp_q.push_back(t4);
        check_period("bnd_old", g);
        check_period("bnd_new", g);

        // 5: reset mid-period with a pending triple and R duty 10 active
        send(mk(10, 3, 3), 1'b1);
        check_period("r10", g);
        send(mk(1, 1, 1), 1'b0);
        repeat (10) @(negedge clk);
        chk("pre_rst_r_lit", 32'(RGB_R), 32'd0);
        chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'b111);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_ps", 32'(period_start), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) begin
            exp_q.push_back(mk(0, 0, 0));
            check_period("post_rst_dark", g);
        end

        // 6: green duty sweep with explicit low-time measurement
        for (int d = 0; d < (1 << DUTY_W); d++) begin
            send(mk(0, d, 0), 1'b1);
            check_period("sweep", g);
            chk("sweep_low_clks", 32'($countones(~g)),
                (d == int'(DMAX)) ? 32'(PERIOD) : 32'(int'(PRESCALE) * d));
        end

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
